seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display in the io group.
//  Scans one digit per refresh slot and drives a one-hot active-low digit select.
//  Decodes each digit's hex nibble to active-low segments.
//  Double-buffers display data so a new value never changes part-way through a scan frame.
// PARAMETERS
//  NUM_DIGITS   8       digits scanned; legal 2..16; index width IW = $clog2(NUM_DIGITS)
//  REFRESH_DIV  100000  clk cycles per digit slot; legal >= 2
// PORTS
//  clk         in   1              system clock, rising edge
//  rst_n       in   1              asynchronous active-low reset
//  load        in   1              1-cycle strobe: capture data/dp_in into staging register
//  data        in   4*NUM_DIGITS   hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
//  dp_in       in   NUM_DIGITS     decimal point per digit, 1 = lit
//  digit_en    in   NUM_DIGITS     per-digit enable, sampled live; 0 = blank that digit
//  sel         out  NUM_DIGITS     digit select, active low, at most one bit 0
//  seg         out  7              {g,f,e,d,c,b,a}, active low
//  dp_out      out  1              decimal point, active low
//  frame_done  out  1              1-cycle pulse when a new frame (digit 0) starts
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
//  Reset values:
//   - counters: div_cnt = 0, idx = NUM_DIGITS-1
//   - registers: staging and display data/dp all 0
//   - outputs: sel = all 1s, seg = 7'h7F, dp_out = 1, frame_done = 0
//  Divider: div_cnt counts 0..REFRESH_DIV-1 and wraps; tc = (div_cnt == REFRESH_DIV-1).
//  On a tc cycle:
//   - idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
//   - sel/seg/dp_out are registered and reflect the new idx on that same edge.
//   - Outputs are otherwise held, so there is no glitch between slots.
//  First slot: digit 0 is shown REFRESH_DIV cycles after rst_n deasserts; outputs stay blank until then.
//  Frame boundary (tc with idx == NUM_DIGITS-1):
//   - display <= staging.
//   - frame_done = 1 for exactly the following cycle.
//  load: staging <= {data, dp_in} on the edge where load = 1; display is untouched until the next frame boundary.
//   - load in the same cycle as a frame boundary: display takes the OLD staging; the new data appears one frame later.
//   - Multiple loads within a frame: the last one wins.
//  Digit output for the selected digit i:
//   - sel[i] = 0, all other sel bits = 1.
//   - seg = hex7(display nibble i), dp_out = ~display_dp[i].
//   - If digit_en[i] = 0 (sampled at the tc edge): sel = all 1s, seg = 7'h7F, dp_out = 1 for the whole slot.
//  hex7 (active low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  Reset mid-frame: all state returns to reset values immediately; staging content is lost.
//  data and dp_in are sampled only on load; digit_en is live. No other inputs are used.
// CONFIGURATION
//  SEG_LZB_EN defined (leading-zero blanking):
//   - At each frame boundary, compute lz_mask from the newly loaded display data.
//   - Digit i is blanked when every nibble at i and above is 0 and its dp bit is 0.
//   - Digit 0 is never blanked.
//   - Blanking is identical to digit_en = 0 and is ANDed with digit_en.
//  SEG_LZB_EN undefined: no lz_mask logic; all enabled digits show their nibble, including leading zeros.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4 unless noted)
//  1. Reset -> sel=4'hF, seg=7F, dp_out=1 until 4 cycles after release.
//     Then sel=4'hE and frame_done pulses once.
//  2. load data=16'h1234, dp_in=4'b0100, digit_en=4'hF -> after the next frame boundary:
//     - sel steps E,D,B,7 every 4 cycles.
//     - seg steps 19,30,24,79.
//     - dp_out is 0 only while sel=B.
//  3. load 16'hAAAA in mid-frame while 16'h5555 is displayed -> remaining slots of that frame still show 12.
//     The next frame shows 08 on all digits.
//  4. load coincident with the frame-boundary tc -> the frame just starting shows the old data.
//     The new data appears in the frame after it.
//  5. digit_en=4'b1011 -> during digit 2's slot, sel=F and seg=7F.
//     Digit 2 is shown again once digit_en is restored.
//  6. SEG_LZB_EN defined, data=16'h0070, dp_in=0:
//     - digits 3 and 2 are blanked; digit 1 shows 78, digit 0 shows 40.
//     - data=16'h0000 -> only digit 0 lit, showing 40.
//     Reassert rst_n mid-slot -> outputs return to reset values immediately.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Signal bundle for seg7_scan_driver: host-side load/data/enable lines and the
// multiplexed display drive lines. master = host, slave = scan driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   sel;
    logic [6:0]              seg;
    logic                    dp_out;
    logic                    frame_done;

    modport master (
        output load, data, dp_in, digit_en,
        input  sel, seg, dp_out, frame_done
    );

    modport slave (
        input  load, data, dp_in, digit_en,
        output sel, seg, dp_out, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered common-anode 7-segment scan driver.
// Optional leading-zero blanking is built when SEG_LZB_EN is defined.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

    logic [DW-1:0]           div_cnt;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_nx;
    logic                    tc;
    logic                    frame_bound;

    logic [4*NUM_DIGITS-1:0] stg_data;
    logic [NUM_DIGITS-1:0]   stg_dp;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [4*NUM_DIGITS-1:0] disp_data_nx;
    logic [NUM_DIGITS-1:0]   disp_dp_nx;
    logic [NUM_DIGITS-1:0]   blank_nx;

    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [NUM_DIGITS-1:0]   sel_nx;
    logic [6:0]              seg_q;
    logic [6:0]              seg_nx;
    logic                    dp_q;
    logic                    dp_nx;
    logic                    fd_q;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tc          = (div_cnt == DIV_LAST);
    assign frame_bound = tc && (idx == IDX_LAST);
    assign idx_nx      = (idx == IDX_LAST) ? '0 : idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= IDX_LAST;
        end else begin
            div_cnt <= tc ? '0 : div_cnt + DW'(1);
            if (tc)
                idx <= idx_nx;
        end
    end

    // Staging takes every load; display only advances at a frame boundary,
    // and a coincident load lands in staging after display has copied the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_data  <= '0;
            stg_dp    <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else begin
            if (bus.load) begin
                stg_data <= bus.data;
                stg_dp   <= bus.dp_in;
            end
            if (frame_bound) begin
                disp_data <= stg_data;
                disp_dp   <= stg_dp;
            end
        end
    end

    // Outputs register on the same edge as the display swap, so look through to staging.
    assign disp_data_nx = frame_bound ? stg_data : disp_data;
    assign disp_dp_nx   = frame_bound ? stg_dp   : disp_dp;

`ifdef SEG_LZB_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] lz_nx;
    logic [NUM_DIGITS-1:0] lz_cur;
    logic                  zero_above;

    always_comb begin
        lz_nx      = '0;
        zero_above = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (stg_data[4*i +: 4] == 4'h0);
            lz_nx[i]   = zero_above && !stg_dp[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lz_mask <= '0;
        else if (frame_bound)
            lz_mask <= lz_nx;
    end

    assign lz_cur   = frame_bound ? lz_nx : lz_mask;
    assign blank_nx = ~bus.digit_en | lz_cur;
`else
    assign blank_nx = ~bus.digit_en;
`endif

    always_comb begin
        nib    = disp_data_nx[idx_nx*4 +: 4];
        sel_nx = '1;
        seg_nx = 7'h7F;
        dp_nx  = 1'b1;
        if (!blank_nx[idx_nx]) begin
            sel_nx[idx_nx] = 1'b0;
            seg_nx         = hex7(nib);
            dp_nx          = ~disp_dp_nx[idx_nx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            fd_q <= frame_bound;
            if (tc) begin
                sel_q <= sel_nx;
                seg_q <= seg_nx;
                dp_q  <= dp_nx;
            end
        end
    end

    assign bus.sel        = sel_q;
    assign bus.seg        = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.frame_done = fd_q;
endmodule
